// File: rtl/audio_pkg.sv
// Shared audio stream package: default sample/slot widths and the PCM sample
// type used by the tone/sine generators and the I2S transmitter.
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 16;
  localparam int AUDIO_SLOT_W   = 16;

  typedef logic [AUDIO_SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider: toggles bclk every BCLK_DIV clk cycles and flags the
// cycle whose closing edge takes bclk from 1 to 0 (fall strobe), so callers
// can update lrclk/sdata on the same edge that bclk falls.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic bclk_o,
  output logic fall_stb_o
);

  localparam int                DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             tc;

  // Divider next state: wrap on terminal count and toggle bclk there.
  always_comb begin
    tc     = (div_q == DIV_LAST);
    div_d  = tc ? '0 : div_q + DIV_W'(1);
    bclk_d = tc ? ~bclk_q : bclk_q;
  end

  // Divider and bclk registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o     = bclk_q;
  assign fall_stb_o = tc & bclk_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: takes mono PCM samples over valid/ready into a one-entry
// holding register and sends each sample on both I2S channels, MSB first,
// with the standard one-bclk delay after each lrclk change.
// Optional feature macro I2S_TX_UNDERRUN_EN adds a saturating 16-bit
// underrun_cnt output counting frames loaded with silence.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = AUDIO_SAMPLE_W,
  parameter int SLOT_W   = AUDIO_SLOT_W,
  parameter int BCLK_DIV = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                bclk,
  output logic                lrclk,
`ifdef I2S_TX_UNDERRUN_EN
  output logic [15:0]         underrun_cnt,
`endif
  output logic                sdata
);

  localparam int               FRAME_W  = 2 * SLOT_W;
  localparam int               CNT_W    = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);

  // Place the sample at the top of the slot; unused low bits are zero.
  function automatic logic [SLOT_W-1:0] msb_align(input logic [SAMPLE_W-1:0] s);
    logic [SLOT_W-1:0] r;
    r = '0;
    r[SLOT_W-1 -: SAMPLE_W] = s;
    return r;
  endfunction

  logic                fall_stb;
  logic                load;
  logic                xfer;

  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                in_ready_q, in_ready_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                lrclk_q, lrclk_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk        (clk),
    .reset      (reset),
    .bclk_o     (bclk),
    .fall_stb_o (fall_stb)
  );

  // The frame load sits on the fall strobe that moves bit_cnt from 0 to 1,
  // giving the one-bit delay after lrclk drops.
  assign load = fall_stb && (bit_cnt_q == '0);
  assign xfer = in_valid && in_ready_q;

  // Handshake, frame position and serialiser next state.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    lrclk_d     = lrclk_q;
    shift_d     = shift_q;

    // A transfer can only land while the register is empty, so an underrun
    // load and a new transfer in the same cycle leave the register full.
    if (load) hold_full_d = 1'b0;
    if (xfer) begin
      hold_d      = in_sample;
      hold_full_d = 1'b1;
    end
    in_ready_d = !hold_full_d;

    if (fall_stb) begin
      bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
      lrclk_d   = (bit_cnt_d >= CNT_SLOT);
      if (load)
        shift_d = hold_full_q ? {msb_align(hold_q), msb_align(hold_q)} : '0;
      else
        shift_d = shift_q << 1;
    end
  end

  // Control and serialiser state; the holding data needs no reset because
  // hold_full_q gates every use of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      in_ready_q  <= 1'b0;
      bit_cnt_q   <= '0;
      lrclk_q     <= 1'b0;
      shift_q     <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      in_ready_q  <= in_ready_d;
      bit_cnt_q   <= bit_cnt_d;
      lrclk_q     <= lrclk_d;
      shift_q     <= shift_d;
    end
  end

  // Holding register data captured on transfer.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign in_ready = in_ready_q;
  assign lrclk    = lrclk_q;
  assign sdata    = shift_q[FRAME_W-1];

`ifdef I2S_TX_UNDERRUN_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // Count frames that had to be loaded with silence, sticking at all-ones.
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (load && !hold_full_q && (underrun_cnt_q != 16'hFFFF))
      underrun_cnt_d = underrun_cnt_q + 16'd1;
  end

  // Underrun counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) underrun_cnt_q <= '0;
    else       underrun_cnt_q <= underrun_cnt_d;
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx (SAMPLE_W=SLOT_W=16, BCLK_DIV=2). An I2S receiver
// model decodes bclk/lrclk/sdata and compares each word against a queue of
// expected words filled when samples are handed over; an empty queue means
// silence is expected. Define I2S_TX_UNDERRUN_EN to cover the counter.
module tb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_sample = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
`ifdef I2S_TX_UNDERRUN_EN
  logic [15:0] underrun_cnt;
`endif

  audio_i2s_tx #(
    .SAMPLE_W (16),
    .SLOT_W   (16),
    .BCLK_DIV (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_sample    (in_sample),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
`ifdef I2S_TX_UNDERRUN_EN
    .underrun_cnt (underrun_cnt),
`endif
    .sdata        (sdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sample;
    logic [15:0] exp_word;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rel = 0;
  logic [15:0] exp_q[$];

  logic        prev_bclk, prev_lr, seen_lr;
  logic [31:0] sh;
  int          falls, rises_before_lr, last_rise, last_lr_rise, words;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // I2S receiver: sample on bclk rise; an lrclk change marks the LSB of the
  // word that just finished.
  task automatic monitor();
    logic [15:0] exp_w;
    if (reset) begin
      prev_bclk       = 1'b0;
      prev_lr         = 1'b0;
      seen_lr         = 1'b0;
      sh              = '0;
      falls           = 0;
      rises_before_lr = 0;
      last_rise       = -1;
      last_lr_rise    = -1;
    end else begin
      if (bclk && !prev_bclk) begin
        if (last_rise >= 0) check("bclk_period", 32'(cyc - last_rise), 32'd4);
        last_rise = cyc;
        sh = {sh[30:0], sdata};
        if (lrclk != prev_lr) begin
          if (exp_q.size() > 0) exp_w = exp_q.pop_front();
          else                  exp_w = 16'h0;
          check(prev_lr ? "right_word" : "left_word", 32'(sh[15:0]), 32'(exp_w));
          words++;
          if (lrclk) begin
            if (!seen_lr) begin
              check("bclk_before_lrclk", 32'(rises_before_lr), 32'd16);
              seen_lr = 1'b1;
            end
            if (last_lr_rise >= 0) check("lrclk_period", 32'(cyc - last_lr_rise), 32'd128);
            last_lr_rise = cyc;
          end
        end
        if (!seen_lr) rises_before_lr++;
        prev_lr = lrclk;
      end
      if (!bclk && prev_bclk) falls++;
      prev_bclk = bclk;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  function automatic int relc();
    return cyc - rel + 1;
  endfunction

  task automatic wait_rel(input int k);
    while (relc() < k) tick();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_bclk", 32'(bclk), 32'd0);
    check("rst_lrclk", 32'(lrclk), 32'd0);
    check("rst_sdata", 32'(sdata), 32'd0);
    reset = 1'b0;
    tick();
    rel = cyc;
    check("ready_after_release", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [15:0] s, input logic [15:0] exp_w, input bit push);
    int n;
    n         = 0;
    in_sample = s;
    in_valid  = 1'b1;
    while (!in_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid  = 1'b0;
    in_sample = ~s;
    if (push) begin
      exp_q.push_back(exp_w);
      exp_q.push_back(exp_w);
    end
  endtask

  initial begin
    vec_t        vecs[8];
    logic        acc;
    int          words0;

    vecs[0] = '{16'hA5C3, 16'hA5C3};
    vecs[1] = '{16'h7FFF, 16'h7FFF};
    vecs[2] = '{16'h8000, 16'h8000};
    vecs[3] = '{16'h0001, 16'h0001};
    vecs[4] = '{16'hFFFF, 16'hFFFF};
    vecs[5] = '{16'h1234, 16'h1234};
    vecs[6] = '{16'h0000, 16'h0000};
    vecs[7] = '{16'h5AA5, 16'h5AA5};

    // Reset and free-running timing.
    do_reset();
    wait_rel(30);
    check("lrclk_low_left", 32'(lrclk), 32'd0);
    wait_rel(70);
    check("lrclk_high_right", 32'(lrclk), 32'd1);
    wait_rel(130);
    check("lrclk_low_frame2", 32'(lrclk), 32'd0);
    wait_rel(200);

    // One sample before the first load; later in_sample changes ignored.
    do_reset();
    send(16'hA5C3, 16'hA5C3, 1'b1);
    wait_rel(300);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // No input at all: every word silent.
    do_reset();
    words0 = words;
`ifdef I2S_TX_UNDERRUN_EN
    wait_rel(6);
    check("t3_underrun_1", 32'(underrun_cnt), 32'd1);
    wait_rel(134);
    check("t3_underrun_2", 32'(underrun_cnt), 32'd2);
    wait_rel(262);
    check("t3_underrun_3", 32'(underrun_cnt), 32'd3);
`endif
    wait_rel(400);
    check("t3_words_seen", 32'(words - words0 >= 5), 32'd1);

    // Back-to-back samples: second stalls until the first frame load.
    do_reset();
    send(16'h7FFF, 16'h7FFF, 1'b1);
    check("t4_stall_ready", 32'(in_ready), 32'd0);
    send(16'h8000, 16'h8000, 1'b1);
    check("t4_load_before_2nd", 32'(falls), 32'd1);
    wait_rel(200);
`ifdef I2S_TX_UNDERRUN_EN
    check("t4_no_underrun", 32'(underrun_cnt), 32'd0);
`endif
    wait_rel(300);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Table of samples streamed continuously, one per frame.
    do_reset();
    for (int i = 0; i < 8; i++) send(vecs[i].sample, vecs[i].exp_word, 1'b1);
    wait_rel(1100);
    check("table_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame at bit_cnt=7 with a sample held.
    do_reset();
    send(16'h1111, 16'h0, 1'b0);
    send(16'h2222, 16'h0, 1'b0);
    while (falls < 7) tick();
    check("t5_held", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    check("t5_rst_bclk", 32'(bclk), 32'd0);
    check("t5_rst_lrclk", 32'(lrclk), 32'd0);
    check("t5_rst_sdata", 32'(sdata), 32'd0);
    check("t5_rst_ready", 32'(in_ready), 32'd0);
    do_reset();
    acc = 1'b0;
    while (relc() < 140) begin
      tick();
      acc = acc | sdata;
    end
    check("t5_silent_frame", 32'(acc), 32'd0);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef I2S_TX_UNDERRUN_EN
    // Counter saturation.
    do_reset();
    force dut.underrun_cnt_q = 16'hFFFE;
    tick();
    release dut.underrun_cnt_q;
    check("t6_preload", 32'(underrun_cnt), 32'hFFFE);
    wait_rel(6);
    check("t6_sat_1", 32'(underrun_cnt), 32'hFFFF);
    wait_rel(134);
    check("t6_sat_2", 32'(underrun_cnt), 32'hFFFF);
    wait_rel(390);
    check("t6_sat_3", 32'(underrun_cnt), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
